pipe_ctrl: RTL and testbench

Pipeline control block for the 5-stage MIPS core. It merges stall requests from ID/EX/MEM into the `stall` vector consumed by the PC and the stage registers. It arbitrates PC redirects between ID branches and MEM exceptions, and holds a branch that arrives while the PC is frozen until the PC can accept it. It sequences the one-cycle pipeline flush on an exception and runs a stall watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/stall_watchdog.sv | 42 ++++
 rtl/pipe_ctrl.sv | 99 +++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: widths, stall-vector bit positions and
// the exception-flush state encoding used by pc and the stage registers.
package pipe_ctrl_pkg;

  localparam int unsigned CTRL_WIDTH      = 6;
  localparam int unsigned INST_ADDR_WIDTH = 32;

  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // A requesting stage freezes itself and every stage upstream of it.
  function automatic logic [CTRL_WIDTH-1:0] stall_vec(input logic req_id,
                                                      input logic req_ex,
                                                      input logic req_mem);
    logic [CTRL_WIDTH-1:0] v;
    int unsigned           top;
    v   = '0;
    top = 0;
    if (req_mem)     top = STALL_MEM + 1;
    else if (req_ex) top = STALL_EX + 1;
    else if (req_id) top = STALL_ID + 1;
    for (int unsigned i = STALL_PC; i < CTRL_WIDTH; i++) begin
      if (i < top) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive PC-stalled cycles and raises a sticky error when the
// pipeline has been frozen for STALL_TIMEOUT cycles in a row.
module stall_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_pc,
  output logic stall_timeout
);

  localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  // Counter saturates at CNT_MAX; one more stalled cycle there trips the flag.
  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (stall_pc) begin
      if (cnt_q == CNT_MAX) to_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign stall_timeout = to_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, branch/exception PC redirect arbitration,
// one-cycle exception flush sequencing and stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stallreq_id,
  input  logic                       stallreq_ex,
  input  logic                       stallreq_mem,
  input  logic                       branch_req,
  input  logic [INST_ADDR_WIDTH-1:0] branch_addr,
  input  logic                       exc_req,
  input  logic [INST_ADDR_WIDTH-1:0] exc_addr,
  output logic [CTRL_WIDTH-1:0]      stall,
  output logic                       flush,
  output logic                       branch_flag,
  output logic [INST_ADDR_WIDTH-1:0] branch_target_addr,
  output logic                       stall_timeout
);

  state_e                     state_q, state_d;
  logic                       pend_valid_q, pend_valid_d;
  logic [INST_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [INST_ADDR_WIDTH-1:0] exc_addr_q, exc_addr_d;

  always_comb begin
    state_d            = state_q;
    pend_valid_d       = pend_valid_q;
    pend_addr_d        = pend_addr_q;
    exc_addr_d         = exc_addr_q;
    stall              = '0;
    flush              = 1'b0;
    branch_flag        = 1'b0;
    branch_target_addr = '0;

    if (!rst) begin
      unique case (state_q)
        ST_FLUSH: begin
          flush              = 1'b1;
          branch_flag        = 1'b1;
          branch_target_addr = exc_addr_q;
          state_d            = ST_HOLDOFF;
        end
        default: begin
          stall = stall_vec(stallreq_id, stallreq_ex, stallreq_mem);
          // An exception taken in IDLE drops any branch, new or pending.
          if (state_q == ST_IDLE && exc_req) begin
            exc_addr_d   = exc_addr;
            pend_valid_d = 1'b0;
            state_d      = ST_FLUSH;
          end else begin
            state_d = ST_IDLE;
            if (pend_valid_q) begin
              branch_flag        = 1'b1;
              branch_target_addr = pend_addr_q;
            end else begin
              branch_flag        = branch_req;
              branch_target_addr = branch_addr;
            end
            // Hold the first branch seen while the PC is frozen until it moves.
            if (!stall[STALL_PC]) begin
              pend_valid_d = 1'b0;
            end else if (!pend_valid_q && branch_req) begin
              pend_valid_d = 1'b1;
              pend_addr_d  = branch_addr;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      exc_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      exc_addr_q   <= exc_addr_d;
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stall_pc     (stall[STALL_PC]),
    .stall_timeout(stall_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a per-cycle behavioural model queues the
// expected outputs, and a negedge monitor pops and compares them.
module tb_pipe_ctrl;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_req, exc_req;
  logic [31:0] branch_addr, exc_addr;
  logic [5:0]  stall;
  logic        flush, branch_flag, stall_timeout;
  logic [31:0] branch_target_addr;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_id       (stallreq_id),
    .stallreq_ex       (stallreq_ex),
    .stallreq_mem      (stallreq_mem),
    .branch_req        (branch_req),
    .branch_addr       (branch_addr),
    .exc_req           (exc_req),
    .exc_addr          (exc_addr),
    .stall             (stall),
    .flush             (flush),
    .branch_flag       (branch_flag),
    .branch_target_addr(branch_target_addr),
    .stall_timeout     (stall_timeout)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        flag;
    logic [31:0] tgt;
    logic        chk_tgt;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: 0 normal, 1 flushing, 2 holdoff.
  int          mode   = 0;
  bit          pend   = 0;
  logic [31:0] pend_a = '0;
  logic [31:0] exc_a  = '0;
  int          run    = 0;
  bit          sticky = 0;

  function automatic logic [5:0] pri(input bit i, input bit e, input bit m);
    if (m) return 6'b011111;
    if (e) return 6'b001111;
    if (i) return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic apply(input bit r, input bit i, input bit e, input bit m,
                       input bit b, input logic [31:0] ba,
                       input bit x, input logic [31:0] xa);
    exp_t ex;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = i; stallreq_ex = e; stallreq_mem = m;
    branch_req = b; branch_addr = ba; exc_req = x; exc_addr = xa;
    ex.stall = '0; ex.flush = 0; ex.flag = 0; ex.tgt = '0; ex.chk_tgt = 1;
    ex.to = sticky;
    if (r) begin
      mode = 0; pend = 0; pend_a = '0; exc_a = '0; run = 0; sticky = 0;
    end else begin
      if (mode == 1) begin
        ex.flush = 1; ex.flag = 1; ex.tgt = exc_a; mode = 2;
      end else begin
        ex.stall = pri(i, e, m);
        if (mode == 0 && x) begin
          exc_a = xa; pend = 0; mode = 1;
        end else begin
          mode = 0;
          if (pend) begin ex.flag = 1; ex.tgt = pend_a; end
          else begin ex.flag = b; ex.tgt = ba; end
          if (!ex.stall[0]) pend = 0;
          else if (!pend && b) begin pend = 1; pend_a = ba; end
        end
      end
      ex.chk_tgt = ex.flag;
      if (ex.stall[0]) begin
        run++;
        if (run >= TO) sticky = 1;
      end else begin
        run = 0;
      end
    end
    q.push_back(ex);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      chk("stall", 32'(stall), 32'(e.stall));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("branch_flag", 32'(branch_flag), 32'(e.flag));
      if (e.chk_tgt) chk("branch_target_addr", branch_target_addr, e.tgt);
      chk("stall_timeout", 32'(stall_timeout), 32'(e.to));
    end
  end

  initial begin
    rst = 1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    branch_req = 0; branch_addr = '0; exc_req = 0; exc_addr = '0;
    @(posedge clk);
    apply(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);

    // Stall priority
    apply(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    apply(0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
    apply(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(1);

    // Branch held across an ID stall
    apply(0, 1, 0, 0, 1, 32'h0000_0100, 0, 32'h0);
    apply(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    apply(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(2);

    // First-latched target wins
    apply(0, 1, 0, 0, 1, 32'h0000_0100, 0, 32'h0);
    apply(0, 1, 0, 0, 1, 32'h0000_0200, 0, 32'h0);
    apply(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(2);

    // Exception beats same-cycle branch; follow-up exceptions ignored
    apply(0, 0, 0, 0, 1, 32'h0000_0300, 1, 32'h0000_0020);
    apply(0, 0, 0, 0, 0, 32'h0, 1, 32'h0000_0040);
    apply(0, 0, 0, 0, 0, 32'h0, 1, 32'h0000_0060);
    idle(2);

    // Watchdog: 7 stalled cycles stay quiet, 8 trip the sticky flag
    apply(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int k = 0; k < 7; k++) apply(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    idle(2);
    for (int k = 0; k < 8; k++) apply(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    idle(3);

    // Reset in FLUSH, and reset with a branch pending
    apply(0, 1, 0, 0, 1, 32'h0000_0500, 0, 32'h0);
    apply(0, 1, 0, 0, 0, 32'h0, 1, 32'h0000_0abc);
    apply(1, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(3);
    apply(0, 1, 0, 0, 1, 32'h0000_0600, 0, 32'h0);
    apply(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    apply(1, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(3);

    // Randomized bursts
    for (int n = 0; n < 400; n++) begin
      int len;
      bit hold_m;
      len    = $urandom_range(1, 12);
      hold_m = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < len; k++) begin
        apply($urandom_range(0, 99) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 4) == 0,
              hold_m || ($urandom_range(0, 5) == 0),
              $urandom_range(0, 3) == 0, $urandom,
              $urandom_range(0, 9) == 0, $urandom);
      end
    end

    idle(2);
    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
